// File: rtl/matmul_operand_sequencer_if.sv
// Operand/result bundle between the matmul sequencer and its environment.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the element stream, out_valid/out_ready on the result.
interface matmul_operand_sequencer_if #(
    parameter int DW = 1,
    parameter int N  = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic [N*N*DW-1:0]   a_mat;
    logic [N*N*DW-1:0]   b_mat;
    logic                start;
    logic [N*N*DW-1:0]   res_in;
    logic                out_valid;
    logic                out_ready;
    logic [N*N*DW-1:0]   out_data;

    // Sequencer side: consumes beats and the array result, drives operands and output.
    modport slave (
        input  in_valid, in_data, res_in, out_ready,
        output in_ready, a_mat, b_mat, start, out_valid, out_data
    );

    // Environment side: element source, systolic array and result sink.
    modport master (
        output in_valid, in_data, res_in, out_ready,
        input  in_ready, a_mat, b_mat, start, out_valid, out_data
    );
endinterface

// File: rtl/matmul_operand_sequencer.sv
// Assembles A then B from an element stream, pulses start, captures the array result.
// Latency: 2*N*N beats to load, result valid LAT edges after the last B beat.
// Backpressure: in_ready low outside loading; result held until out_ready.
// Optional build macro MATSEQ_BCOLMAJOR_EN: B beats arrive column-major.
module matmul_operand_sequencer #(
    parameter int DW  = 1,
    parameter int N   = 3,
    parameter int LAT = 9
) (
    input  logic clk,
    input  logic rst_n,
    matmul_operand_sequencer_if.slave bus
);
    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      b_pos;
    logic [CW-1:0]      cnt;
    logic [NN*DW-1:0]   a_q;
    logic [NN*DW-1:0]   b_q;
    logic [NN*DW-1:0]   out_q;
    logic               start_q;
    logic               out_valid_q;
    logic               in_ready_w;
    logic               beat;
    logic               last_idx;

    // Ready is a pure state decode so it needs no register of its own.
    assign in_ready_w = (state == LOAD_A) || (state == LOAD_B);
    assign beat       = bus.in_valid && in_ready_w;
    assign last_idx   = (idx == IW'(NN - 1));

    // Destination element of the current B beat.
    always_comb begin
        b_pos = idx;
`ifdef MATSEQ_BCOLMAJOR_EN
        b_pos = IW'((int'(idx) % N) * N + int'(idx) / N);
`endif
    end

    // Sequencer FSM with all operand, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD_A;
            idx         <= '0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (beat) begin
                        a_q[idx*DW +: DW] <= bus.in_data;
                        if (last_idx) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        b_q[b_pos*DW +: DW] <= bus.in_data;
                        if (last_idx) begin
                            idx     <= '0;
                            cnt     <= '0;
                            start_q <= 1'b1;
                            state   <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(LAT - 1)) begin
                        out_q       <= bus.res_in;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.a_mat     = a_q;
    assign bus.b_mat     = b_q;
    assign bus.start     = start_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
endmodule
